// File: rtl/lane_scheduler.sv
// Two-lane byte striper: accepts a serial byte stream and distributes it
// across up to two downstream lanes in strict round-robin order. A paused
// target lane stalls the input rather than redirecting the byte.

// Per-lane output register: one-cycle valid pulse, data held between writes.
module lane_stripe_reg (
  input  logic       clk_f,
  input  logic       reset_L,
  input  logic       wr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       vld
);

  // Register the lane byte on write; valid pulses for exactly one cycle.
  always_ff @(posedge clk_f or negedge reset_L) begin
    if (!reset_L) begin
      dout <= 8'h00;
      vld  <= 1'b0;
    end else begin
      vld <= wr;
      if (wr) dout <= din;
    end
  end

endmodule

module lane_scheduler #(
  parameter int IDLE_TO = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk_f,
  input  logic             reset_L,
  input  logic [7:0]       data_in,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [1:0]       lane_en,
  input  logic             pause_0,
  input  logic             pause_1,
  output logic [7:0]       data_stripe_0,
  output logic [7:0]       data_stripe_1,
  output logic             valid_stripe_0,
  output logic             valid_stripe_1,
  output logic             active,
  output logic [CNT_W-1:0] byte_count
);

  localparam int         NUM_LANES = 2;
  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] STRIPE    = 1'b1;
  localparam logic [3:0] IDLE_TO_C = 4'(IDLE_TO);

  logic [0:0] state;
  logic       ptr;
  logic [1:0] cfg;
  logic [3:0] idle_cnt;
  logic       hs;
  logic       first_lane;
  logic       pair_done;

  logic [NUM_LANES-1:0]      pause_v;
  logic [NUM_LANES-1:0]      wr_v;
  logic [NUM_LANES-1:0]      vld_v;
  logic [NUM_LANES-1:0][7:0] dat_v;

  assign pause_v    = {pause_1, pause_0};
  assign ready_in   = (state == STRIPE) && !pause_v[ptr];
  assign hs         = valid_in && ready_in;
  // With only lane 1 enabled the pair "starts" on lane 1.
  assign first_lane = (cfg == 2'b10);
  assign pair_done  = (idle_cnt == IDLE_TO_C) && (ptr == first_lane);
  assign active     = (state == STRIPE);

  // State, lane pointer and latched lane config.
  always_ff @(posedge clk_f or negedge reset_L) begin
    if (!reset_L) begin
      state <= IDLE;
      ptr   <= 1'b0;
      cfg   <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          cfg <= lane_en;
          if (valid_in && (lane_en != 2'b00)) begin
            state <= STRIPE;
            ptr   <= (lane_en == 2'b10);
          end
        end
        STRIPE: begin
          if (hs && (cfg == 2'b11)) ptr <= ~ptr;
          if (pair_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Idle counter: any valid cycle restarts it; saturates while striping.
  always_ff @(posedge clk_f or negedge reset_L) begin
    if (!reset_L)
      idle_cnt <= 4'd0;
    else if (valid_in)
      idle_cnt <= 4'd0;
    else if ((state == STRIPE) && (idle_cnt != IDLE_TO_C))
      idle_cnt <= idle_cnt + 4'd1;
  end

  // Accepted-byte counter, wraps naturally.
  always_ff @(posedge clk_f or negedge reset_L) begin
    if (!reset_L)
      byte_count <= '0;
    else if (hs)
      byte_count <= byte_count + 1'b1;
  end

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      assign wr_v[g] = hs && (int'(ptr) == g);
      lane_stripe_reg u_lane (
        .clk_f   (clk_f),
        .reset_L (reset_L),
        .wr      (wr_v[g]),
        .din     (data_in),
        .dout    (dat_v[g]),
        .vld     (vld_v[g])
      );
    end
  endgenerate

  assign data_stripe_0  = dat_v[0];
  assign data_stripe_1  = dat_v[1];
  assign valid_stripe_0 = vld_v[0];
  assign valid_stripe_1 = vld_v[1];

endmodule

// File: tb/tb_lane_scheduler.sv
// Randomized scoreboard bench for lane_scheduler. The driver steps a
// behavioural model and queues each expected lane byte; the monitor pops
// and compares whenever a lane valid appears.
module tb_lane_scheduler;

  localparam int IDLE_TO = 4;
  localparam int CNT_W   = 8;

  logic             clk_f = 1'b0;
  logic             reset_L;
  logic [7:0]       data_in;
  logic             valid_in;
  logic             ready_in;
  logic [1:0]       lane_en;
  logic             pause_0, pause_1;
  logic [7:0]       data_stripe_0, data_stripe_1;
  logic             valid_stripe_0, valid_stripe_1;
  logic             active;
  logic [CNT_W-1:0] byte_count;

  lane_scheduler #(.IDLE_TO(IDLE_TO), .CNT_W(CNT_W)) dut (
    .clk_f          (clk_f),
    .reset_L        (reset_L),
    .data_in        (data_in),
    .valid_in       (valid_in),
    .ready_in       (ready_in),
    .lane_en        (lane_en),
    .pause_0        (pause_0),
    .pause_1        (pause_1),
    .data_stripe_0  (data_stripe_0),
    .data_stripe_1  (data_stripe_1),
    .valid_stripe_0 (valid_stripe_0),
    .valid_stripe_1 (valid_stripe_1),
    .active         (active),
    .byte_count     (byte_count)
  );

  always #5 clk_f = ~clk_f;

  typedef struct { int lane; int data; } exp_t;
  exp_t sbq[$];

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 0;

  // Model: striping flag, current lane, latched enables, idle run, count.
  int m_stripe, m_ptr, m_cfg, m_idle, m_cnt;
  int n_stripe, n_ptr, n_cfg, n_idle, n_cnt;
  int exp_ready, exp_active, exp_cnt;
  int m_last[2];

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_clear();
    m_stripe = 0; m_ptr = 0; m_cfg = 0; m_idle = 0; m_cnt = 0;
    n_stripe = 0; n_ptr = 0; n_cfg = 0; n_idle = 0; n_cnt = 0;
    m_last[0] = 0; m_last[1] = 0;
    sbq.delete();
  endtask

  // One cycle of the rules: decide acceptance, queue the lane byte,
  // compute what the scheduler looks like next cycle.
  task automatic model_step(input int v, input int d, input int le,
                            input int p0, input int p1);
    int blocked;
    exp_active = m_stripe;
    exp_cnt    = m_cnt;
    n_stripe = m_stripe; n_ptr = m_ptr; n_cfg = m_cfg; n_cnt = m_cnt;
    if (m_stripe == 0) begin
      exp_ready = 0;
      n_cfg = le;
      if (v != 0 && le != 0) begin
        n_stripe = 1;
        n_ptr = (le == 2) ? 1 : 0;
      end
    end else begin
      blocked = (m_ptr == 1) ? p1 : p0;
      exp_ready = (blocked != 0) ? 0 : 1;
      if (v != 0 && blocked == 0) begin
        sbq.push_back('{m_ptr, d});
        n_cnt = (m_cnt + 1) % (1 << CNT_W);
        if (m_cfg == 3) n_ptr = 1 - m_ptr;
      end
      if (m_idle == IDLE_TO && m_ptr == ((m_cfg == 2) ? 1 : 0)) n_stripe = 0;
    end
    if (v != 0)                            n_idle = 0;
    else if (m_stripe != 0 && m_idle < IDLE_TO) n_idle = m_idle + 1;
    else                                   n_idle = m_idle;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"},  int'(ready_in), 0);
    chk({tag, "_vld0"},   int'(valid_stripe_0), 0);
    chk({tag, "_vld1"},   int'(valid_stripe_1), 0);
    chk({tag, "_dat0"},   int'(data_stripe_0), 0);
    chk({tag, "_dat1"},   int'(data_stripe_1), 0);
    chk({tag, "_active"}, int'(active), 0);
    chk({tag, "_count"},  int'(byte_count), 0);
  endtask

  // mode 0..3: fixed lane_en; 4: random each cycle; 5: 11 then 01 halfway.
  task automatic run_phase(input int ncyc, input int mode,
                           input int vprob, input int pprob);
    int v, d, le, p0, p1;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk_f); #1;
      m_stripe = n_stripe; m_ptr = n_ptr; m_cfg = n_cfg;
      m_idle = n_idle; m_cnt = n_cnt;
      v  = ($urandom_range(99) < vprob) ? 1 : 0;
      d  = $urandom_range(255);
      p0 = ($urandom_range(99) < pprob) ? 1 : 0;
      p1 = ($urandom_range(99) < pprob) ? 1 : 0;
      if (mode < 4)       le = mode;
      else if (mode == 4) le = $urandom_range(3);
      else                le = (i < ncyc / 2) ? 3 : 1;
      valid_in = v[0]; data_in = d[7:0]; lane_en = le[1:0];
      pause_0 = p0[0]; pause_1 = p1[0];
      model_step(v, d, le, p0, p1);
      mon_en = 1;
    end
  endtask

  // Reset asserted between edges: outputs must clear without a clock.
  task automatic mid_reset();
    @(posedge clk_f); #3;
    mon_en = 0;
    reset_L = 1'b0;
    valid_in = 1'b0; pause_0 = 1'b0; pause_1 = 1'b0; lane_en = 2'b00;
    #1;
    chk_reset_vals("async_rst");
    model_clear();
    @(negedge clk_f);
    @(negedge clk_f);
    reset_L = 1'b1;
  endtask

  // Monitor: compare lane outputs against the scoreboard each cycle.
  always @(negedge clk_f) begin
    if (mon_en && reset_L) begin
      exp_t e;
      chk("ready_in",   int'(ready_in),   exp_ready);
      chk("active",     int'(active),     exp_active);
      chk("byte_count", int'(byte_count), exp_cnt);
      chk("both_valid", int'(valid_stripe_0 & valid_stripe_1), 0);
      for (int l = 0; l < 2; l++) begin
        if ((l == 0) ? valid_stripe_0 : valid_stripe_1) begin
          if (sbq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_valid: lane %0d pulsed, scoreboard empty (t=%0t)", l, $time);
          end else begin
            e = sbq.pop_front();
            chk("lane_target", l, e.lane);
            m_last[l] = e.data;
          end
        end
      end
      chk("data_stripe_0", int'(data_stripe_0), m_last[0]);
      chk("data_stripe_1", int'(data_stripe_1), m_last[1]);
    end
  end

  initial begin
    reset_L = 1'b0;
    data_in = 8'h00; valid_in = 1'b0; lane_en = 2'b00;
    pause_0 = 1'b0; pause_1 = 1'b0;
    model_clear();
    repeat (3) @(negedge clk_f);
    chk_reset_vals("reset");
    reset_L = 1'b1;

    run_phase(60,  3, 100, 0);   // both lanes, back-to-back
    run_phase(80,  2, 70, 20);   // lane 1 only
    run_phase(80,  1, 70, 20);   // lane 0 only
    run_phase(200, 3, 60, 40);   // both lanes with pauses
    run_phase(200, 3, 15, 10);   // sparse traffic, repeated idle exits
    run_phase(200, 4, 50, 20);   // lane_en churning, incl. 00
    run_phase(120, 5, 40, 10);   // 11 -> 01 while striping
    mid_reset();
    run_phase(300, 3, 100, 0);   // >256 bytes, counter wrap
    mid_reset();
    run_phase(200, 4, 60, 30);
    run_phase(20,  3, 0, 0);     // drain
    chk("sb_drain", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
